// File: rtl/dequant_unpack.sv
// Widening stage ahead of the MAC array: unpacks LANES signed narrow lanes per word,
// removes the zero point and left-shifts each lane into a signed OUT_W value, one per cycle.
module dequant_unpack #(
    parameter int LANES   = 4,
    parameter int IN_W    = 8,
    parameter int OUT_W   = 16,
    parameter int SHIFT_W = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [LANES*IN_W-1:0]   s_data,
    input  logic                    s_last,
    input  logic [IN_W-1:0]         cfg_zp,
    input  logic [SHIFT_W-1:0]      cfg_shift,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [OUT_W-1:0] m_data,
    output logic                    m_last,
    output logic                    busy
);

    localparam int LANE_W = $clog2(LANES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t                  state_p0;
    state_t                  state_nxt;
    logic [LANE_W-1:0]       lane_p0;
    logic [LANE_W-1:0]       lane_nxt;
    logic [LANES*IN_W-1:0]   word_p0;
    logic signed [IN_W-1:0]  zp_p0;
    logic [SHIFT_W-1:0]      shift_p0;
    logic                    last_p0;
    logic                    rdy_en_p0;
    logic                    at_last;
    logic                    accept;

    function automatic logic signed [IN_W-1:0] lane_sel(
        input logic [LANES*IN_W-1:0] w,
        input logic [LANE_W-1:0]     idx
    );
        return w[idx*IN_W +: IN_W];
    endfunction

    // The difference fits in IN_W+1 bits and the OUT_W bound covers the largest shift,
    // so neither the subtraction nor the shift can overflow.
    function automatic logic signed [OUT_W-1:0] dequant(
        input logic signed [IN_W-1:0] v,
        input logic signed [IN_W-1:0] zp,
        input logic [SHIFT_W-1:0]     sh
    );
        logic signed [IN_W:0]    d;
        logic signed [OUT_W-1:0] wide;
        d    = {v[IN_W-1], v} - {zp[IN_W-1], zp};
        wide = OUT_W'(d);
        return wide <<< sh;
    endfunction

    always_comb begin
        at_last   = (lane_p0 == LAST_LANE);
        // Ready reaches back through m_ready so a new word can follow the last lane without a bubble.
        s_ready   = rdy_en_p0 && ((state_p0 == IDLE) || (at_last && m_ready));
        accept    = s_valid && s_ready;
        state_nxt = state_p0;
        lane_nxt  = lane_p0;
        case (state_p0)
            IDLE: begin
                if (accept) begin
                    state_nxt = EMIT;
                    lane_nxt  = '0;
                end
            end
            EMIT: begin
                if (m_ready) begin
                    if (!at_last) begin
                        lane_nxt = lane_p0 + 1'b1;
                    end else if (accept) begin
                        lane_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                        lane_nxt  = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                lane_nxt  = '0;
            end
        endcase
    end

    // Stage p0: held word, its configuration snapshot and the lane pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0  <= IDLE;
            lane_p0   <= '0;
            word_p0   <= '0;
            zp_p0     <= '0;
            shift_p0  <= '0;
            last_p0   <= 1'b0;
            rdy_en_p0 <= 1'b0;
        end else begin
            state_p0  <= state_nxt;
            lane_p0   <= lane_nxt;
            rdy_en_p0 <= 1'b1;
            if (accept) begin
                word_p0  <= s_data;
                zp_p0    <= cfg_zp;
                shift_p0 <= cfg_shift;
                last_p0  <= s_last;
            end
        end
    end

    always_comb begin
        m_valid = (state_p0 == EMIT);
        busy    = m_valid;
        m_last  = m_valid && last_p0 && at_last;
        m_data  = m_valid ? dequant(lane_sel(word_p0, lane_p0), zp_p0, shift_p0) : '0;
    end

endmodule

// File: tb/tb_dequant_unpack.sv
// Scoreboard bench for dequant_unpack: expectations queued at drive time, checked as lanes leave.
module tb_dequant_unpack;

    localparam int LANES   = 4;
    localparam int IN_W    = 8;
    localparam int OUT_W   = 16;
    localparam int SHIFT_W = 3;

    typedef struct {
        logic [15:0] d;
        logic        l;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  s_valid = 1'b0;
    logic                  s_ready;
    logic [31:0]           s_data = '0;
    logic                  s_last = 1'b0;
    logic [7:0]            cfg_zp = '0;
    logic [2:0]            cfg_shift = '0;
    logic                  m_valid;
    logic                  m_ready = 1'b1;
    logic signed [15:0]    m_data;
    logic                  m_last;
    logic                  busy;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   last_cnt = 0;

    dequant_unpack #(
        .LANES  (LANES),
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .SHIFT_W(SHIFT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .cfg_zp   (cfg_zp),
        .cfg_shift(cfg_shift),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] v, input logic [7:0] zp,
                                          input logic [2:0] sh);
        int vi, zi, r;
        vi = int'($signed(v));
        zi = int'($signed(zp));
        r  = (vi - zi) * (1 << sh);
        return r[15:0];
    endfunction

    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", {16'h0, m_data}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_data", {16'h0, m_data}, {16'h0, e.d});
                chk("sb_last", {31'h0, m_last}, {31'h0, e.l});
                if (m_last) last_cnt++;
            end
        end
    end

    task automatic send_word(input logic [31:0] w, input logic last, input logic [7:0] zp,
                             input logic [2:0] sh);
        int  n;
        bit  ok;
        exp_t e;
        s_data    = w;
        s_last    = last;
        cfg_zp    = zp;
        cfg_shift = sh;
        s_valid   = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            e.d = model(w[i*8 +: 8], zp, sh);
            e.l = last && (i == LANES - 1);
            sb.push_back(e);
        end
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain", sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lc;
        logic [15:0] held;

        // reset state
        #3;
        chk("rst_vld", {31'h0, m_valid}, 32'd0);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_srdy", {31'h0, s_ready}, 32'd0);
        chk("rst_data", {16'h0, m_data}, 32'd0);
        chk("rst_last", {31'h0, m_last}, 32'd0);
        #9 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_srdy", {31'h0, s_ready}, 32'd1);
        chk("post_rst_vld", {31'h0, m_valid}, 32'd0);
        @(posedge clk);
        #1;

        // 1: plain unpack, four consecutive outputs then idle
        send_word(32'h807FFF01, 1'b0, 8'h00, 3'd0);
        for (int i = 0; i < LANES; i++) begin
            @(negedge clk);
            chk("t1_vld", {31'h0, m_valid}, 32'd1);
            if (i == 0) chk("t1_lane0", {16'h0, m_data}, 32'h0000_0001);
        end
        @(negedge clk);
        chk("t1_idle", {31'h0, m_valid}, 32'd0);
        drain();

        // 2: extreme zero point and shift
        send_word(32'h017F807F, 1'b0, 8'h80, 3'd7);
        @(negedge clk);
        chk("t2_pos", {16'h0, m_data}, 32'h0000_7F80);
        drain();
        send_word(32'h7F00FF80, 1'b0, 8'h7F, 3'd7);
        @(negedge clk);
        chk("t2_neg", {16'h0, m_data}, 32'h0000_8080);
        drain();

        // 3: back-to-back words, no bubble, ready only on the final lane
        send_word(32'h04030201, 1'b0, 8'h01, 3'd1);
        fork
            send_word(32'h08070605, 1'b0, 8'hFE, 3'd2);
            begin
                for (int i = 0; i < 2 * LANES; i++) begin
                    @(negedge clk);
                    chk("t3_vld", {31'h0, m_valid}, 32'd1);
                    if (i < 2 * LANES - 1)
                        chk("t3_srdy", {31'h0, s_ready}, {31'h0, (i == LANES - 1)});
                end
            end
        join
        drain();

        // 4: backpressure on lane 2
        send_word(32'h40C02010, 1'b0, 8'h10, 3'd2);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        held = model(8'hC0, 8'h10, 3'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_hold_data", {16'h0, m_data}, {16'h0, held});
            chk("t4_hold_last", {31'h0, m_last}, 32'd0);
            chk("t4_hold_srdy", {31'h0, s_ready}, 32'd0);
            chk("t4_hold_vld", {31'h0, m_valid}, 32'd1);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        drain();

        // 5: s_last on second word, config changes while held
        lc = last_cnt;
        send_word(32'h11223344, 1'b0, 8'h00, 3'd1);
        send_word(32'hF0E0D0C0, 1'b1, 8'hF0, 3'd3);
        cfg_shift = 3'd7;
        cfg_zp    = 8'h55;
        drain();
        chk("t5_last_count", last_cnt - lc, 32'd1);

        // 6: reset mid-word
        send_word(32'h04030201, 1'b0, 8'h00, 3'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("t6_vld", {31'h0, m_valid}, 32'd0);
        chk("t6_busy", {31'h0, busy}, 32'd0);
        chk("t6_srdy", {31'h0, s_ready}, 32'd0);
        chk("t6_data", {16'h0, m_data}, 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("t6_post_srdy", {31'h0, s_ready}, 32'd1);
        chk("t6_post_vld", {31'h0, m_valid}, 32'd0);
        @(posedge clk);
        #1;
        send_word(32'h0A0B0C0D, 1'b1, 8'h03, 3'd4);
        @(negedge clk);
        chk("t6_lane0", {16'h0, m_data}, {16'h0, model(8'h0D, 8'h03, 3'd4)});
        drain();

        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dequant_unpack.md
Name: dequant_unpack

Overview:
- Widening counterpart to the output saturation stage of the NPU datapath.
- Accepts packed signed activation words of LANES narrow values on a valid/ready stream.
- Serialises the lanes, subtracts a zero point and left-shifts each one into a signed wide value.
- Emits one wide value per cycle on a valid/ready stream toward the MAC/accumulator input.

Parameters:
- LANES, 4, number of narrow values per input word (>=2).
- IN_W, 8, width of each packed signed input lane.
- OUT_W, 16, width of the signed output value; must satisfy OUT_W >= IN_W+1+(2^SHIFT_W-1).
- SHIFT_W, 3, width of the shift config; shift range 0..2^SHIFT_W-1.

Ports:
- clk, input, 1, clock; all logic rising-edge.
- rst_n, input, 1, asynchronous active-low reset.
- s_valid, input, 1, input word valid.
- s_ready, output, 1, block can accept a word this cycle.
- s_data, input, LANES*IN_W, packed signed lanes; lane 0 in bits [IN_W-1:0].
- s_last, input, 1, word is the final word of a tensor row.
- cfg_zp, input, IN_W, signed zero point; sampled with each accepted word.
- cfg_shift, input, SHIFT_W, unsigned left shift; sampled with each accepted word.
- m_valid, output, 1, output value valid.
- m_ready, input, 1, downstream accepts the value.
- m_data, output, OUT_W, signed dequantised value.
- m_last, output, 1, final lane of a word that arrived with s_last.
- busy, output, 1, high while a word is held (m_valid).

Behaviour:
- Reset: the asynchronous assertion of rst_n clears the following.
  - State goes to IDLE; lane counter goes to 0.
  - Holding registers (word, zp, shift, last flag) go to 0.
  - m_valid=0, m_last=0, m_data=0, busy=0, s_ready=0 while rst_n low.
  - After release, s_ready=1 from the first clock edge onward.
  - Reset mid-word discards the remaining lanes, with no partial output after release.
- States:
  - IDLE: no word held; s_ready=1; m_valid=0.
  - EMIT: word held; m_valid=1; m_data shows the lane selected by the lane counter.
- Transitions:
  - IDLE, s_valid&&s_ready: latch s_data/cfg_zp/cfg_shift/s_last, set lane=0, go to EMIT.
  - EMIT, m_valid&&m_ready, lane<LANES-1: lane increments.
  - EMIT, m_valid&&m_ready, lane==LANES-1, no new word accepted: go to IDLE.
  - EMIT, m_valid&&m_ready, lane==LANES-1, s_valid high: new word latched the same cycle, lane=0, remain in EMIT. This gives back-to-back words with no bubble.
- s_ready is 1 in IDLE, or in EMIT when lane==LANES-1 && m_ready. This is a combinational path from m_ready.
- Latency: a word accepted at edge N presents lane 0 at m_data after edge N. A word with no backpressure takes exactly LANES cycles of output.
- Arithmetic:
  - d = sext(lane) - sext(zp), computed at IN_W+1 bits; no wrap is possible.
  - m_data = sext_OUT_W(d) << shift.
  - The parameter constraint guarantees no overflow, so no saturation logic is needed.
- m_data and m_last are a function of registered state only and stay stable while m_valid && !m_ready.
- m_last = held last flag && lane==LANES-1.
- Config changes while a word is held do not affect that word.
- s_data and s_last are ignored when s_ready=0.

Test Plan:
1. Single word, zp=0, shift=0, lanes {0x01,0xFF,0x7F,0x80}, m_ready=1 -> m_data 1, -1, 127, -128 on 4 consecutive cycles; m_valid then drops to 0.
2. Zero point and shift, zp=0x80 (-128), shift=7, lane 0x7F -> m_data=255<<7=32640 (0x7F80). With zp=0x7F and lane 0x80 -> -255<<7=-32640 (0x8080).
3. Back-to-back words with s_valid held high and m_ready=1 -> 8 consecutive valid outputs, no bubble, and s_ready pulses exactly on the 4th lane of word 1.
4. Backpressure: m_ready low for 3 cycles at lane 2 -> m_data/m_last held constant, lane not advanced, s_ready=0 throughout; output resumes in order when m_ready rises.
5. s_last=1 on the second of two words -> m_last high only on lane 3 of word 2. Changing cfg_shift mid-word leaves the remaining lanes of the held word unchanged.
6. rst_n asserted during lane 1 -> m_valid/busy/s_ready go to 0 immediately. After release, s_ready=1, and the next accepted word starts at lane 0 with no stale output.
